// File: rtl/filter_seq_ctrl.sv
// filter_seq_ctrl: periodic sample capture into a 16-entry circular buffer,
// followed by a sequenced moving average over the newest N entries.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous, active-high reset
//   in        - signed 16-bit sample, captured on each tick
//   SW        - averaging depth select: 00->1, 01->2, 10->4, 11->16
//   out       - signed registered average, held between updates
//   out_valid - one-cycle pulse when out updates
//   busy      - high whenever the sequencer is not idle
//
// Parameter TICK_DIV: clk cycles per sample tick (32..2^20).
// Optional build macro SMOOTH_ROUND_EN: round half toward +inf in the divide
// step instead of truncating toward -inf.
module filter_seq_ctrl #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic [1:0]  SW,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, DIVIDE} state_t;

  state_t      state;
  state_t      state_next;
  logic [CW-1:0] count;
  logic        tick;
  logic        tick_q;
  logic [15:0] buffer [16];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic [19:0] acc;
  logic [19:0] acc_adj;
  logic [1:0]  mode;
  logic [4:0]  taps;
  logic [2:0]  shift;

  function automatic logic [4:0] taps_for(input logic [1:0] sel);
    case (sel)
      2'b00:   taps_for = 5'd1;
      2'b01:   taps_for = 5'd2;
      2'b10:   taps_for = 5'd4;
      default: taps_for = 5'd16;
    endcase
  endfunction

  function automatic logic [2:0] shift_for(input logic [1:0] sel);
    case (sel)
      2'b00:   shift_for = 3'd0;
      2'b01:   shift_for = 3'd1;
      2'b10:   shift_for = 3'd2;
      default: shift_for = 3'd4;
    endcase
  endfunction

  assign tick = (count == CW'(TICK_DIV - 1));
  assign busy = (state != IDLE);

  // Tick generation and sample capture; runs regardless of sequencer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      tick_q <= 1'b0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      count  <= tick ? '0 : count + 1'b1;
      tick_q <= tick;
      if (tick) begin
        buffer[wr_ptr] <= in;
        wr_ptr         <= wr_ptr + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // tick_q delays the start by one cycle; a tick seen while busy is dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick_q) state_next = LOAD;
      LOAD:    state_next = ACCUM;
      ACCUM:   if (taps == 5'd1) state_next = DIVIDE;
      DIVIDE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift   = shift_for(mode);
    acc_adj = acc;
`ifdef SMOOTH_ROUND_EN
    if (shift != 3'd0) acc_adj = acc + (20'd1 << (shift - 3'd1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      mode      <= '0;
      rd_ptr    <= '0;
      taps      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        LOAD: begin
          acc    <= '0;
          mode   <= SW;
          rd_ptr <= wr_ptr - 4'd1;
          taps   <= taps_for(SW);
        end
        ACCUM: begin
          acc    <= acc + {{4{buffer[rd_ptr][15]}}, buffer[rd_ptr]};
          rd_ptr <= rd_ptr - 4'd1;
          taps   <= taps - 5'd1;
        end
        DIVIDE: begin
          out       <= 16'($signed(acc_adj) >>> shift);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
